// File: rtl/alu_accum.sv
// Accumulator ALU: single-cycle logic/arith ops on A and acc, plus an optional
// iterative shift-add multiplier compiled in only when ALU_ACCUM_MUL_EN is defined.
module alu_accum #(
  parameter int WIDTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset_b,
  input  logic [WIDTH-1:0]     A,
  input  logic [2:0]           op,
  input  logic                 start,
  input  logic                 acc_clr,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 carry,
  output logic                 zero
);

  localparam int AW = 2 * WIDTH;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ACC  = 3'b001;
  localparam logic [2:0] OP_NNOR = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SWAP = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
`ifdef ALU_ACCUM_MUL_EN
  localparam logic [2:0] OP_MUL  = 3'b110;
`endif

  logic [AW-1:0]    r_acc;
  logic             r_carry;
  logic             r_done;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_add;
  logic [AW:0]      w_sum;
  logic [AW-1:0]    w_res;
  logic             w_res_c;

  assign w_b   = r_acc[WIDTH-1:0];
  assign w_add = {1'b0, A} + {1'b0, w_b};
  assign w_sum = {1'b0, r_acc} + (AW+1)'(A);

  always_comb begin
    w_res   = r_acc;
    w_res_c = r_carry;
    case (op)
      OP_ADD:  begin w_res = AW'(w_add);                    w_res_c = 1'b0;      end
      OP_ACC:  begin w_res = w_sum[AW-1:0];                 w_res_c = w_sum[AW]; end
      OP_NNOR: begin w_res = {~(A & w_b), ~(A | w_b)};      w_res_c = 1'b0;      end
      OP_XOR:  begin w_res = {A ^ w_b, ~(A ^ w_b)};         w_res_c = 1'b0;      end
      OP_SWAP: begin w_res = {w_b, ~A};                     w_res_c = 1'b0;      end
      OP_ROL:  begin w_res = {r_acc[AW-2:0], r_acc[AW-1]};  w_res_c = 1'b0;      end
      // 110 (when no multiplier, or handled by the FSM) and 111 leave acc/carry alone
      default: begin end
    endcase
  end

`ifdef ALU_ACCUM_MUL_EN
  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [AW-1:0]    r_prod;
  logic [AW-1:0]    w_prod_nxt;
  logic             w_mul_last;

  assign w_mul_last = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == S_MUL) ? r_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !acc_clr && (op == OP_MUL)) w_state_nxt = S_MUL;
      S_MUL:   if (acc_clr || w_mul_last)                w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands are latched every idle cycle, so the values present at launch stick.
  always_ff @(posedge Clock) begin
    if (r_state == S_IDLE) begin
      r_mcand  <= AW'(A);
      r_mplier <= w_b;
      r_prod   <= '0;
    end else begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign busy = (r_state == S_MUL);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (acc_clr) begin
        r_acc   <= '0;
        r_carry <= 1'b0;
      end
`ifdef ALU_ACCUM_MUL_EN
      else if (r_state == S_MUL) begin
        if (w_mul_last) begin
          r_acc   <= w_prod_nxt;
          r_carry <= 1'b0;
          r_done  <= 1'b1;
        end
      end else if (start && (op != OP_MUL)) begin
`else
      else if (start) begin
`endif
        r_acc   <= w_res;
        r_carry <= w_res_c;
        r_done  <= 1'b1;
      end
    end
  end

  assign acc   = r_acc;
  assign carry = r_carry;
  assign done  = r_done;
  assign zero  = (r_acc == '0);

endmodule

// File: tb/tb_alu_accum.sv
// Bench for alu_accum (WIDTH=4): vector table through a done-driven scoreboard,
// plus hand sequences for back-to-back, clear priority, multiply and async reset.
module tb_alu_accum;

  localparam int WIDTH = 4;
  localparam int AW    = 2 * WIDTH;

  logic             Clock   = 1'b0;
  logic             Reset_b = 1'b1;
  logic [WIDTH-1:0] A       = '0;
  logic [2:0]       op      = '0;
  logic             start   = 1'b0;
  logic             acc_clr = 1'b0;
  logic             busy, done, carry, zero;
  logic [AW-1:0]    acc;

  alu_accum #(.WIDTH(WIDTH)) dut (
    .Clock(Clock), .Reset_b(Reset_b), .A(A), .op(op), .start(start),
    .acc_clr(acc_clr), .busy(busy), .done(done), .acc(acc),
    .carry(carry), .zero(zero)
  );

  always #5 Clock = ~Clock;

  typedef struct { logic [AW-1:0] acc; logic carry; } exp_t;
  typedef struct {
    logic [AW-1:0]    init;
    logic [WIDTH-1:0] a;
    logic [2:0]       op;
    logic [AW-1:0]    exp_acc;
    logic             exp_c;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: done=1 required 0 (acc=%0h) at %0t", acc, $time);
        end else begin
          e = sb.pop_front();
          chk("sb_acc", 32'(acc), 32'(e.acc));
          chk("sb_carry", 32'(carry), 32'(e.carry));
          chk("sb_zero", 32'(zero), 32'(e.acc == '0));
        end
      end
    end
  end

  task automatic wait_drain();
    for (int k = 0; k < 4 * WIDTH + 8 && sb.size() != 0; k++) begin
      @(posedge Clock); #1;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [2:0] o,
                       input logic [AW-1:0] ea, input logic ec);
    exp_t e;
    A = a; op = o; start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    e.acc = ea; e.carry = ec;
    sb.push_back(e);
    wait_drain();
  endtask

  task automatic clr();
    acc_clr = 1'b1;
    @(posedge Clock); #1;
    acc_clr = 1'b0;
  endtask

  // clear, ADD the high nibble into an empty acc, then {B,~A} puts the low nibble in place
  task automatic load(input logic [AW-1:0] v);
    logic [WIDTH-1:0] hi, lo;
    hi = v[AW-1:WIDTH];
    lo = v[WIDTH-1:0];
    clr();
    do_op(hi, 3'b000, AW'(hi), 1'b0);
    do_op(~lo, 3'b100, v, 1'b0);
  endtask

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
`ifdef ALU_ACCUM_MUL_EN
    logic mul_en = 1'b1;
`else
    logic mul_en = 1'b0;
`endif
    exp_t e;

    vecs[0]  = '{8'h03, 4'h5, 3'b000, 8'h08, 1'b0};
    vecs[1]  = '{8'hFE, 4'h3, 3'b001, 8'h01, 1'b1};
    vecs[2]  = '{8'h06, 4'hA, 3'b010, 8'hD1, 1'b0};
    vecs[3]  = '{8'h06, 4'hA, 3'b011, 8'hC3, 1'b0};
    vecs[4]  = '{8'h5A, 4'h3, 3'b100, 8'hAC, 1'b0};
    vecs[5]  = '{8'h81, 4'h0, 3'b101, 8'h03, 1'b0};
    vecs[6]  = '{8'h5A, 4'h0, 3'b101, 8'hB4, 1'b0};
    vecs[7]  = '{8'h10, 4'hF, 3'b001, 8'h1F, 1'b0};
    vecs[8]  = '{8'hAF, 4'hF, 3'b000, 8'h1E, 1'b0};
    vecs[9]  = '{8'h3C, 4'h9, 3'b111, 8'h3C, 1'b0};
    vecs[10] = '{8'h0D, 4'hB, 3'b110, mul_en ? 8'h8F : 8'h0D, 1'b0};
    vecs[11] = '{8'hC7, 4'h0, 3'b110, mul_en ? 8'h00 : 8'hC7, 1'b0};
    vecs[12] = '{8'hFF, 4'hF, 3'b110, mul_en ? 8'hE1 : 8'hFF, 1'b0};
    vecs[13] = '{8'hFF, 4'h1, 3'b001, 8'h00, 1'b1};

    // reset state
    #2 Reset_b = 1'b0;
    #1;
    chk("rst_acc", 32'(acc), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_zero", 32'(zero), 1);
    @(posedge Clock); @(posedge Clock); #1;
    Reset_b = 1'b1;

    for (int i = 0; i < NV; i++) begin
      load(vecs[i].init);
      do_op(vecs[i].a, vecs[i].op, vecs[i].exp_acc, vecs[i].exp_c);
    end

    // HOLD keeps a set carry; then acc_clr wins over a simultaneous start
    load(8'hFE);
    do_op(4'h3, 3'b001, 8'h01, 1'b1);
    do_op(4'h5, 3'b111, 8'h01, 1'b1);
    A = 4'h3; op = 3'b000; start = 1'b1; acc_clr = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0; acc_clr = 1'b0;
    @(negedge Clock);
    chk("clr_acc", 32'(acc), 0);
    chk("clr_carry", 32'(carry), 0);
    chk("clr_done", 32'(done), 0);
    chk("clr_zero", 32'(zero), 1);
    @(posedge Clock); #1;

    // back-to-back ADDs of 1 give consecutive done pulses
    A = 4'h1; op = 3'b000; start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      e.acc = AW'(i); e.carry = 1'b0;
      sb.push_back(e);
      @(posedge Clock); #1;
    end
    start = 1'b0;
    @(negedge Clock);
    chk("b2b_done", 32'(done), 1);
    chk("b2b_acc", 32'(acc), 3);
    @(negedge Clock);
    chk("b2b_done_end", 32'(done), 0);
    wait_drain();

`ifdef ALU_ACCUM_MUL_EN
    // MUL with a second start mid-op and A changing underneath
    load(8'h0D);
    A = 4'hB; op = 3'b110; start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    e.acc = 8'h8F; e.carry = 1'b0;
    sb.push_back(e);
    @(negedge Clock);
    chk("mul_busy1", 32'(busy), 1);
    @(posedge Clock); #1;
    A = 4'h7; op = 3'b000; start = 1'b1;
    @(negedge Clock);
    chk("mul_busy2", 32'(busy), 1);
    @(posedge Clock); #1;
    start = 1'b0;
    @(negedge Clock);
    chk("mul_busy3", 32'(busy), 1);
    @(negedge Clock);
    chk("mul_busy4", 32'(busy), 1);
    chk("mul_done_early", 32'(done), 0);
    @(negedge Clock);
    chk("mul_busy_end", 32'(busy), 0);
    chk("mul_done", 32'(done), 1);
    chk("mul_acc", 32'(acc), 32'h8F);
    @(negedge Clock);
    chk("mul_done_once", 32'(done), 0);
    chk("mul_no_relaunch", 32'(busy), 0);
    chk("mul_acc_hold", 32'(acc), 32'h8F);
    @(posedge Clock); #1;
    wait_drain();

    // acc_clr in the second MUL cycle aborts without done
    load(8'h0D);
    A = 4'hB; op = 3'b110; start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    @(posedge Clock); #1;
    acc_clr = 1'b1;
    @(posedge Clock); #1;
    acc_clr = 1'b0;
    @(negedge Clock);
    chk("abort_acc", 32'(acc), 0);
    chk("abort_zero", 32'(zero), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    repeat (WIDTH + 2) @(negedge Clock);
    chk("abort_busy_late", 32'(busy), 0);
    @(posedge Clock); #1;

    // asynchronous reset between edges mid-MUL
    load(8'h0D);
    A = 4'hB; op = 3'b110; start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    @(posedge Clock); #2;
    Reset_b = 1'b0;
    #1;
    chk("mrst_acc", 32'(acc), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    #2 Reset_b = 1'b1;
    repeat (WIDTH + 2) @(negedge Clock);
    chk("mrst_busy_late", 32'(busy), 0);
    @(posedge Clock); #1;
`endif

    // asynchronous reset while done is high, then a start on the first edge after release
    clr();
    A = 4'h9; op = 3'b000; start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    #2 Reset_b = 1'b0;
    #1;
    chk("arst_acc", 32'(acc), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_carry", 32'(carry), 0);
    chk("arst_busy", 32'(busy), 0);
    #3 Reset_b = 1'b1;
    do_op(4'h6, 3'b000, 8'h06, 1'b0);

    repeat (3) @(posedge Clock);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
